// File: rtl/riscv_pkg.sv
// Shared MEM-stage types and small helpers for the load/store unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic      RD;
        logic      WR;
        mem_size_t SIZE;
        logic      UNS;
    } MEM_ctrl;

    // Encoding shared with the localparam state constants inside lsu_dmem.
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_REQ    = 2'd1,
        LSU_WAIT_R = 2'd2
    } lsu_state_t;

    // Byte-enable pattern for a size, placed on the addressed byte lane.
    function automatic logic [3:0] be_of(input mem_size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            BYTE:    be = 4'b0001 << off;
            HALF:    be = 4'b0011 << off;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so any enabled lane sees it.
    function automatic logic [31:0] wdata_rep(input mem_size_t sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            BYTE:    r = {4{wd[7:0]}};
            HALF:    r = {2{wd[15:0]}};
            WORD:    r = wd;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Natural alignment check; bytes are always aligned.
    function automatic logic is_aligned(input mem_size_t sz, input logic [1:0] off);
        logic ok;
        case (sz)
            BYTE:    ok = 1'b1;
            HALF:    ok = ~off[0];
            WORD:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Data-memory request/grant/response bus between the LSU and data memory.
interface lsu_dmem_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req_out;
    logic              dmem_we_out;
    logic [3:0]        dmem_be_out;
    logic [ADDR_W-1:0] dmem_addr_out;
    logic [31:0]       dmem_wdata_out;
    logic              dmem_gnt_in;
    logic              dmem_rvalid_in;
    logic [31:0]       dmem_rdata_in;

    modport master (
        output dmem_req_out, dmem_we_out, dmem_be_out, dmem_addr_out, dmem_wdata_out,
        input  dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
    );

    modport slave (
        input  dmem_req_out, dmem_we_out, dmem_be_out, dmem_addr_out, dmem_wdata_out,
        output dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
    );
endinterface

// File: rtl/lsu_dmem_load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        uns,
    output logic [31:0] word
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension according to size and signedness.
    always_comb begin
        byte_s = rdata[{offset, 3'b000} +: 8];
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            BYTE:    word = {{24{~uns & byte_s[7]}}, byte_s};
            HALF:    word = {{16{~uns & half_s[15]}}, half_s};
            WORD:    word = rdata;
            default: word = 32'h0000_0000;
        endcase
    end
endmodule

// File: rtl/lsu_dmem.sv
// MEM-stage load/store unit: drives the data-memory handshake, stalls the
// pipeline while an access is outstanding, and returns extended load data.
module lsu_dmem
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int ADDR_W      = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  MEM_ctrl     MEMctrl_in,
    input  logic [31:0] MEMaddr_in,
    input  logic [31:0] MEMwdata_in,
    output logic [31:0] MEMdata_MEM_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_err_out,
    lsu_dmem_if.master  dmem
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;

    localparam int              CNT_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              expire_s;
    logic [31:0]       hold_r;

    // Request context captured when an access is accepted in IDLE.
    logic              we_r;
    logic [3:0]        be_r;
    logic [ADDR_W-3:0] waddr_r;
    logic [31:0]       wdata_r;
    logic [1:0]        off_r;
    mem_size_t         size_r;
    logic              uns_r;

    logic              acc_s;
    logic              aligned_s;
    logic              start_s;
    logic              cap_s;
    logic [31:0]       ld_word_s;

    assign acc_s     = MEMctrl_in.RD | MEMctrl_in.WR;
    assign aligned_s = is_aligned(MEMctrl_in.SIZE, MEMaddr_in[1:0]);
    assign start_s   = (state_r == ST_IDLE) & acc_s & aligned_s;

    // The increment happening this cycle is what "reaches" the limit, so the
    // abort lands TIMEOUT_CYC-1 cycles after the access was first presented.
    assign cnt_inc_s = cnt_r + CNT_ONE;
    assign expire_s  = (cnt_inc_s == TO_LIM);

    lsu_load_align u_align (
        .rdata  (dmem.dmem_rdata_in),
        .offset (off_r),
        .size   (size_r),
        .uns    (uns_r),
        .word   (ld_word_s)
    );

    // Next-state and all combinational outputs; everything is forced low in reset.
    always_comb begin
        state_nxt_s         = state_r;
        dmem.dmem_req_out   = 1'b0;
        dmem.dmem_we_out    = 1'b0;
        dmem.dmem_be_out    = 4'b0000;
        dmem.dmem_addr_out  = {ADDR_W{1'b0}};
        dmem.dmem_wdata_out = 32'h0000_0000;
        stall_out           = 1'b0;
        misalign_out        = 1'b0;
        bus_err_out         = 1'b0;
        MEMdata_MEM_out     = hold_r;
        cap_s               = 1'b0;
        if (rst_in) begin
            state_nxt_s     = ST_IDLE;
            MEMdata_MEM_out = 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_s && !aligned_s) begin
                        misalign_out = 1'b1;
                    end else if (acc_s) begin
                        dmem.dmem_req_out   = 1'b1;
                        dmem.dmem_we_out    = MEMctrl_in.WR;
                        dmem.dmem_be_out    = be_of(MEMctrl_in.SIZE, MEMaddr_in[1:0]);
                        dmem.dmem_addr_out  = {MEMaddr_in[ADDR_W-1:2], 2'b00};
                        dmem.dmem_wdata_out = wdata_rep(MEMctrl_in.SIZE, MEMwdata_in);
                        if (dmem.dmem_gnt_in && MEMctrl_in.WR) begin
                            state_nxt_s = ST_IDLE;
                        end else if (dmem.dmem_gnt_in) begin
                            state_nxt_s = ST_WAIT_R;
                            stall_out   = 1'b1;
                        end else begin
                            state_nxt_s = ST_REQ;
                            stall_out   = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    dmem.dmem_req_out   = 1'b1;
                    dmem.dmem_we_out    = we_r;
                    dmem.dmem_be_out    = be_r;
                    dmem.dmem_addr_out  = {waddr_r, 2'b00};
                    dmem.dmem_wdata_out = wdata_r;
                    if (dmem.dmem_gnt_in && we_r) begin
                        state_nxt_s = ST_IDLE;
                    end else if (dmem.dmem_gnt_in) begin
                        state_nxt_s = ST_WAIT_R;
                        stall_out   = 1'b1;
                    end else if (expire_s) begin
                        state_nxt_s = ST_IDLE;
                        bus_err_out = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                    end
                end
                ST_WAIT_R: begin
                    if (dmem.dmem_rvalid_in) begin
                        MEMdata_MEM_out = ld_word_s;
                        cap_s           = 1'b1;
                        state_nxt_s     = ST_IDLE;
                    end else if (expire_s) begin
                        state_nxt_s = ST_IDLE;
                        bus_err_out = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, timeout counter (cleared on each state change) and load hold register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hold_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r != ST_IDLE) begin
                cnt_r <= cnt_inc_s;
            end
            if (cap_s) begin
                hold_r <= ld_word_s;
            end
        end
    end

    // Capture the request context so REQ/WAIT_R do not depend on upstream inputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            we_r    <= 1'b0;
            be_r    <= 4'b0000;
            waddr_r <= {(ADDR_W-2){1'b0}};
            wdata_r <= 32'h0000_0000;
            off_r   <= 2'b00;
            size_r  <= BYTE;
            uns_r   <= 1'b0;
        end else if (start_s) begin
            we_r    <= MEMctrl_in.WR;
            be_r    <= be_of(MEMctrl_in.SIZE, MEMaddr_in[1:0]);
            waddr_r <= MEMaddr_in[ADDR_W-1:2];
            wdata_r <= wdata_rep(MEMctrl_in.SIZE, MEMwdata_in);
            off_r   <= MEMaddr_in[1:0];
            size_r  <= MEMctrl_in.SIZE;
            uns_r   <= MEMctrl_in.UNS;
        end
    end
endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: stores, loads, misalignment, timeout, reset.
module tb_lsu_dmem;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    MEM_ctrl     ctrl;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] mdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    int          checks;
    int          failures;

    lsu_dmem_if #(.ADDR_W(32)) bus ();

    lsu_dmem #(.TIMEOUT_CYC(16), .ADDR_W(32)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .MEMctrl_in      (ctrl),
        .MEMaddr_in      (maddr),
        .MEMwdata_in     (mwdata),
        .MEMdata_MEM_out (mdata),
        .stall_out       (stall),
        .misalign_out    (misalign),
        .bus_err_out     (bus_err),
        .dmem            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input logic rd, input logic wr, input mem_size_t sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd);
        ctrl.RD   = rd;
        ctrl.WR   = wr;
        ctrl.SIZE = sz;
        ctrl.UNS  = uns;
        maddr     = a;
        mwdata    = wd;
    endtask

    task automatic set_bus(input logic g, input logic rv, input logic [31:0] rd);
        bus.dmem_gnt_in    = g;
        bus.dmem_rvalid_in = rv;
        bus.dmem_rdata_in  = rd;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rst_req",   {31'd0, bus.dmem_req_out}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_data",  mdata, 32'h0);
        chk("rst_be",    {28'd0, bus.dmem_be_out}, 32'd0);
        next_cyc();
        rst = 1'b0;

        // Store byte 0xA5 @0x103, granted in the same cycle
        set_mem(1'b0, 1'b1, BYTE, 1'b0, 32'h103, 32'h0000_00A5);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("sb_req",   {31'd0, bus.dmem_req_out}, 32'd1);
        chk("sb_we",    {31'd0, bus.dmem_we_out}, 32'd1);
        chk("sb_be",    {28'd0, bus.dmem_be_out}, 32'h8);
        chk("sb_wdata", bus.dmem_wdata_out, 32'hA5A5_A5A5);
        chk("sb_addr",  bus.dmem_addr_out, 32'h100);
        chk("sb_stall", {31'd0, stall}, 32'd0);
        next_cyc();
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("sb_idle_req",   {31'd0, bus.dmem_req_out}, 32'd0);
        chk("sb_idle_stall", {31'd0, stall}, 32'd0);
        next_cyc();

        // Load half signed @0x202: gnt at cycle 2, rvalid at cycle 4
        set_mem(1'b1, 1'b0, HALF, 1'b0, 32'h202, 32'h0);
        @(negedge clk);
        chk("lh_c0_req",   {31'd0, bus.dmem_req_out}, 32'd1);
        chk("lh_c0_we",    {31'd0, bus.dmem_we_out}, 32'd0);
        chk("lh_c0_be",    {28'd0, bus.dmem_be_out}, 32'hC);
        chk("lh_c0_addr",  bus.dmem_addr_out, 32'h200);
        chk("lh_c0_stall", {31'd0, stall}, 32'd1);
        next_cyc();
        @(negedge clk);
        chk("lh_c1_req",   {31'd0, bus.dmem_req_out}, 32'd1);
        chk("lh_c1_be",    {28'd0, bus.dmem_be_out}, 32'hC);
        chk("lh_c1_stall", {31'd0, stall}, 32'd1);
        next_cyc();
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lh_c2_req",   {31'd0, bus.dmem_req_out}, 32'd1);
        chk("lh_c2_stall", {31'd0, stall}, 32'd1);
        next_cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lh_c3_req",   {31'd0, bus.dmem_req_out}, 32'd0);
        chk("lh_c3_stall", {31'd0, stall}, 32'd1);
        next_cyc();
        set_bus(1'b0, 1'b1, 32'h8001_1234);
        @(negedge clk);
        chk("lh_c4_data",  mdata, 32'hFFFF_8001);
        chk("lh_c4_stall", {31'd0, stall}, 32'd0);
        next_cyc();
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lh_hold", mdata, 32'hFFFF_8001);
        next_cyc();

        // Load byte unsigned @0x201, then a back-to-back store
        set_mem(1'b1, 1'b0, BYTE, 1'b1, 32'h201, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lbu_be",    {28'd0, bus.dmem_be_out}, 32'h2);
        chk("lbu_stall", {31'd0, stall}, 32'd1);
        next_cyc();
        set_bus(1'b0, 1'b1, 32'h0000_F700);
        @(negedge clk);
        chk("lbu_data",  mdata, 32'h0000_00F7);
        chk("lbu_stall2", {31'd0, stall}, 32'd0);
        next_cyc();
        set_mem(1'b0, 1'b1, WORD, 1'b0, 32'h300, 32'h1234_5678);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("sw_be",    {28'd0, bus.dmem_be_out}, 32'hF);
        chk("sw_wdata", bus.dmem_wdata_out, 32'h1234_5678);
        chk("sw_data",  mdata, 32'h0000_00F7);
        next_cyc();
        // Stray rvalid in IDLE must not disturb the hold register
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        set_bus(1'b0, 1'b1, 32'h5555_AAAA);
        @(negedge clk);
        chk("stray_data",  mdata, 32'h0000_00F7);
        chk("stray_stall", {31'd0, stall}, 32'd0);
        next_cyc();

        // Load byte signed @0x203
        set_mem(1'b1, 1'b0, BYTE, 1'b0, 32'h203, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lb_be", {28'd0, bus.dmem_be_out}, 32'h8);
        next_cyc();
        set_bus(1'b0, 1'b1, 32'h9A00_0000);
        @(negedge clk);
        chk("lb_data", mdata, 32'hFFFF_FF9A);
        next_cyc();

        // Misaligned word load @0x002 and half store @0x101
        set_mem(1'b1, 1'b0, WORD, 1'b0, 32'h002, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("mis_w_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_w_req",   {31'd0, bus.dmem_req_out}, 32'd0);
        chk("mis_w_stall", {31'd0, stall}, 32'd0);
        next_cyc();
        set_mem(1'b0, 1'b1, HALF, 1'b0, 32'h101, 32'hBEEF);
        @(negedge clk);
        chk("mis_h_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_h_req",   {31'd0, bus.dmem_req_out}, 32'd0);
        next_cyc();
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        next_cyc();

        // Timeout: no gnt, abort at cycle 15
        set_mem(1'b0, 1'b1, WORD, 1'b0, 32'h400, 32'hCAFE_F00D);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk($sformatf("to_stall_c%0d", c), {31'd0, stall}, 32'd1);
            chk($sformatf("to_berr_c%0d", c), {31'd0, bus_err}, 32'd0);
            next_cyc();
        end
        @(negedge clk);
        chk("to_berr_c15",  {31'd0, bus_err}, 32'd1);
        chk("to_stall_c15", {31'd0, stall}, 32'd0);
        next_cyc();
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("to_req_after",  {31'd0, bus.dmem_req_out}, 32'd0);
        chk("to_berr_after", {31'd0, bus_err}, 32'd0);
        next_cyc();
        set_mem(1'b0, 1'b1, BYTE, 1'b0, 32'h404, 32'h11);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("to_idle_req",   {31'd0, bus.dmem_req_out}, 32'd1);
        chk("to_idle_stall", {31'd0, stall}, 32'd0);
        next_cyc();

        // Grant lands in the abort cycle: completes normally
        set_mem(1'b0, 1'b1, WORD, 1'b0, 32'h408, 32'h0BAD_CAFE);
        set_bus(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 15; c++) begin
            next_cyc();
        end
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("tog_berr",  {31'd0, bus_err}, 32'd0);
        chk("tog_stall", {31'd0, stall}, 32'd0);
        chk("tog_req",   {31'd0, bus.dmem_req_out}, 32'd1);
        chk("tog_addr",  bus.dmem_addr_out, 32'h408);
        next_cyc();
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("tog_berr_after", {31'd0, bus_err}, 32'd0);
        next_cyc();

        // Reset while in WAIT_R, then a late rvalid
        set_mem(1'b1, 1'b0, BYTE, 1'b0, 32'h500, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0);
        next_cyc();
        set_mem(1'b0, 1'b0, BYTE, 1'b0, 32'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_stall", {31'd0, stall}, 32'd0);
        chk("rw_rst_data",  mdata, 32'h0);
        next_cyc();
        rst = 1'b0;
        set_bus(1'b0, 1'b1, 32'h0000_00FF);
        @(negedge clk);
        chk("rw_late_data",  mdata, 32'h0);
        chk("rw_late_stall", {31'd0, stall}, 32'd0);
        chk("rw_late_req",   {31'd0, bus.dmem_req_out}, 32'd0);
        next_cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rw_hold", mdata, 32'h0);
        next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
